frac_n_ctrl: RTL

//  Sequencing controller for the fractional-N divider: owns reset and input of the MASH modulator,

---
 rtl/frac_n_pkg.sv | 23 ++
 rtl/div_ratio_sat.sv | 42 ++++
 rtl/frac_n_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/frac_n_pkg.sv
// Shared types and helpers for the fractional-N divider sequencing controller.
package frac_n_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF    = 2'd0,
    ST_MRST   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  // Bits needed to hold a down-counter value in the range 0..max_count.
  function automatic int cnt_width(input int max_count);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) <= max_count) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/div_ratio_sat.sv
// Adds the signed modulator dither to the integer ratio and saturates the
// result into the range the multi-modulus divider can actually produce.
module div_ratio_sat #(
  parameter int WIDTH_INT = 8,
  parameter int ORDER     = 3,
  parameter int DIV_MIN   = 16,
  parameter int DIV_MAX   = 255
) (
  input  logic [WIDTH_INT-1:0] n_int,
  input  logic [ORDER-1:0]     dither,
  input  logic                 use_dither,
  output logic [WIDTH_INT-1:0] ratio,
  output logic                 clamp
);

  // Two guard bits: one for the carry above the unsigned range, one for sign.
  localparam int SUM_W = WIDTH_INT + 2;
  localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(DIV_MIN);
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(DIV_MAX);

  logic signed [SUM_W-1:0] base;
  logic signed [SUM_W-1:0] offs;
  logic signed [SUM_W-1:0] sum;

  assign base = signed'({2'b00, n_int});
  assign offs = use_dither ? signed'({{(SUM_W-ORDER){dither[ORDER-1]}}, dither}) : '0;
  assign sum  = base + offs;

  // Saturate the sum to the divider limits and flag when that happened.
  always_comb begin
    ratio = sum[WIDTH_INT-1:0];
    clamp = 1'b0;
    if (sum < MIN_S) begin
      ratio = WIDTH_INT'(DIV_MIN);
      clamp = 1'b1;
    end else if (sum > MAX_S) begin
      ratio = WIDTH_INT'(DIV_MAX);
      clamp = 1'b1;
    end
  end

endmodule

// File: rtl/frac_n_ctrl.sv
// Sequencing controller for the fractional-N divider: owns the MASH modulator
// reset and input word, produces the per-cycle division ratio and applies
// new channel settings through a valid/ready handshake.
//
//   state  | meaning
//   OFF    | loop idle, modulator held in reset, config may be written
//   MRST   | modulator reset pulse, undithered ratio to the divider
//   SETTLE | modulator running but its output not yet trusted
//   RUN    | dithered ratio, seamless config updates allowed
module frac_n_ctrl
  import frac_n_pkg::*;
#(
  parameter int WIDTH_MODULUS = 16,
  parameter int ORDER         = 3,
  parameter int WIDTH_INT     = 8,
  parameter int DIV_MIN       = 16,
  parameter int DIV_MAX       = 255,
  parameter int DEFAULT_INT   = 64,
  parameter int RST_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [WIDTH_INT-1:0]     cfg_n_int,
  input  logic [WIDTH_MODULUS-1:0] cfg_n_frac,
  input  logic                     cfg_reseed,
  output logic                     mod_rst,
  output logic [WIDTH_MODULUS-1:0] mod_data_in,
  input  logic [ORDER-1:0]         mod_data_out,
  output logic [WIDTH_INT-1:0]     div_ratio,
  output logic                     div_valid,
  output logic                     clamp_flag,
  input  logic                     clamp_clr,
  output logic [STATE_W-1:0]       state_o
);

  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [WIDTH_INT-1:0]     n_int_r;
  logic [WIDTH_MODULUS-1:0] n_frac_r;
  logic                     cfg_xfer;
  logic                     use_dither;
  logic [WIDTH_INT-1:0]     sat_ratio;
  logic                     sat_clamp;

  assign cfg_xfer   = cfg_valid & cfg_ready;
  // Dither only feeds the divider while the modulator stays in RUN; a reseed
  // edge already uses the plain integer ratio.
  assign use_dither = (state == ST_RUN) && (state_nxt == ST_RUN);
  assign state_o    = state;

  div_ratio_sat #(
    .WIDTH_INT (WIDTH_INT),
    .ORDER     (ORDER),
    .DIV_MIN   (DIV_MIN),
    .DIV_MAX   (DIV_MAX)
  ) u_sat (
    .n_int      (n_int_r),
    .dither     (mod_data_out),
    .use_dither (use_dither),
    .ratio      (sat_ratio),
    .clamp      (sat_clamp)
  );

  // Next-state decision; enable low overrides everything.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF:    state_nxt = ST_MRST;
        ST_MRST:   if (cnt == '0) state_nxt = ST_SETTLE;
        ST_SETTLE: if (cnt == '0) state_nxt = ST_RUN;
        ST_RUN:    if (cfg_xfer && cfg_reseed) state_nxt = ST_MRST;
        default:   state_nxt = ST_OFF;
      endcase
    end
  end

  // State, shared phase counter, config registers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      cnt         <= '0;
      n_int_r     <= WIDTH_INT'(DEFAULT_INT);
      n_frac_r    <= '0;
      mod_rst     <= 1'b1;
      mod_data_in <= '0;
      div_ratio   <= WIDTH_INT'(DEFAULT_INT);
      div_valid   <= 1'b0;
      clamp_flag  <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      state       <= state_nxt;
      mod_data_in <= n_frac_r;
      if (cfg_xfer) begin
        n_int_r  <= cfg_n_int;
        n_frac_r <= cfg_n_frac;
      end

      case (state_nxt)
        ST_MRST:   cnt <= (state != ST_MRST)   ? RST_LOAD    : cnt - 1'b1;
        ST_SETTLE: cnt <= (state != ST_SETTLE) ? SETTLE_LOAD : cnt - 1'b1;
        default:   cnt <= '0;
      endcase

      mod_rst   <= (state_nxt == ST_OFF) || (state_nxt == ST_MRST);
      cfg_ready <= (state_nxt == ST_OFF) || (state_nxt == ST_RUN);
      div_valid <= (state_nxt != ST_OFF);

      // The ratio holds its last value while idle; only freshly loaded
      // ratios can raise the sticky clamp indication.
      if (state_nxt != ST_OFF) div_ratio <= sat_ratio;

      if ((state_nxt != ST_OFF) && sat_clamp) clamp_flag <= 1'b1;
      else if (clamp_clr)                     clamp_flag <= 1'b0;
    end
  end

endmodule
